uart_adc_ctrl: RTL

UART_ADC_CTRL -- requirements
Module: uart_adc_ctrl

---
 rtl/uart_adc_pkg.sv | 27 ++
 rtl/uart_adc_cmd_rx.sv | 101 ++++++++++
 rtl/uart_adc_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_adc_pkg.sv
// Shared definitions for the UART-controlled ADC sample streamer.
// Holds the command byte codes, the ADC sample width, the TX frame length,
// the TX sequencer state type and the helper that builds the frame's
// middle byte.
package uart_adc_pkg;

  localparam int ADC_W     = 12;
  localparam int FRAME_LEN = 3;

  localparam logic [7:0] CMD_START = 8'h53;  // 'S'
  localparam logic [7:0] CMD_STOP  = 8'h50;  // 'P'
  localparam logic [7:0] CMD_DEC   = 8'h44;  // 'D'

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_HDR  = 2'd1,
    TX_HI   = 2'd2,
    TX_LO   = 2'd3
  } tx_state_e;

  // Middle frame byte: sequence number in the upper nibble, sample MSBs below.
  function automatic logic [7:0] frame_hi_byte(input logic [3:0]       seq,
                                               input logic [ADC_W-1:0] sample);
    return {seq, sample[ADC_W-1:8]};
  endfunction

endpackage

// File: rtl/uart_adc_cmd_rx.sv
// RX command parser.
// Ports:
//   clk, reset           - clock and synchronous active-high reset
//   rx_data/valid/error  - incoming UART byte stream
//   rx_ready             - byte accepted (1 outside reset)
//   streaming            - streaming enable set by 'S', cleared by 'P'
//   dec                  - decimation value captured after 'D'
//   err_cnt              - saturating count of errored bytes
//   cmd_start/cmd_stop   - strobes in the acceptance cycle of 'S' / 'P'
//   dec_load             - strobe in the acceptance cycle of a new decimation value
module uart_adc_cmd_rx
  import uart_adc_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_error,
  output logic             rx_ready,
  output logic             streaming,
  output logic [7:0]       dec,
  output logic [ERR_W-1:0] err_cnt,
  output logic             cmd_start,
  output logic             cmd_stop,
  output logic             dec_load
);

  logic             rx_ready_r;
  logic             streaming_r;
  logic [7:0]       dec_r;
  logic [ERR_W-1:0] err_cnt_r;
  logic             await_arg_r;

  logic accept_s;
  logic good_s;
  logic bad_s;
  logic dec_arm_s;

  assign accept_s = rx_valid & rx_ready_r;
  assign good_s   = accept_s & ~rx_error;
  assign bad_s    = accept_s & rx_error;

  // Decode an error-free accepted byte; errored bytes never reach the parser.
  always_comb begin
    cmd_start = 1'b0;
    cmd_stop  = 1'b0;
    dec_load  = 1'b0;
    dec_arm_s = 1'b0;
    if (good_s) begin
      if (await_arg_r) begin
        dec_load = 1'b1;
      end else begin
        case (rx_data)
          CMD_START: cmd_start = 1'b1;
          CMD_STOP:  cmd_stop  = 1'b1;
          CMD_DEC:   dec_arm_s = 1'b1;
          default:   dec_arm_s = 1'b0;
        endcase
      end
    end else begin
      dec_arm_s = 1'b0;
    end
  end

  // Parser state, streaming enable, decimation value and error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_ready_r  <= 1'b0;
      streaming_r <= 1'b0;
      dec_r       <= 8'h00;
      err_cnt_r   <= {ERR_W{1'b0}};
      await_arg_r <= 1'b0;
    end else begin
      rx_ready_r <= 1'b1;
      if (bad_s && (err_cnt_r != {ERR_W{1'b1}})) begin
        err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end
      if (dec_load) begin
        dec_r       <= rx_data;
        await_arg_r <= 1'b0;
      end
      if (dec_arm_s) begin
        await_arg_r <= 1'b1;
      end
      if (cmd_start) begin
        streaming_r <= 1'b1;
      end
      if (cmd_stop) begin
        streaming_r <= 1'b0;
      end
    end
  end

  assign rx_ready  = rx_ready_r;
  assign streaming = streaming_r;
  assign dec       = dec_r;
  assign err_cnt   = err_cnt_r;

endmodule

// File: rtl/uart_adc_ctrl.sv
// UART-controlled ADC sample streamer.
// Commands arrive on the RX stream ('S' start, 'P' stop, 'D' <n> decimate).
// While streaming, one of every DEC+1 ADC samples is kept in a one-entry
// holding register and sent on the TX stream as HDR_BYTE, {seq, msb}, lsb.
// Ports:
//   clk_clk, reset_reset               - clock, synchronous active-high reset
//   rx_data/valid/error, rx_ready      - from_uart stream
//   tx_data/valid/error, tx_ready      - to_uart stream
//   adc_data, adc_valid                - ADC samples
//   streaming, overrun, err_cnt        - status
module uart_adc_ctrl
  import uart_adc_pkg::*;
#(
  parameter logic [7:0] HDR_BYTE = 8'hA5,
  parameter int         ERR_W    = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             rx_error,
  output logic             rx_ready,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_error,
  input  logic             tx_ready,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             streaming,
  output logic             overrun,
  output logic [ERR_W-1:0] err_cnt
);

  logic       streaming_s;
  logic [7:0] dec_s;
  logic       cmd_start_s;
  logic       cmd_stop_s;
  logic       dec_load_s;

  uart_adc_cmd_rx #(
    .ERR_W(ERR_W)
  ) u_cmd_rx (
    .clk      (clk_clk),
    .reset    (reset_reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_error (rx_error),
    .rx_ready (rx_ready),
    .streaming(streaming_s),
    .dec      (dec_s),
    .err_cnt  (err_cnt),
    .cmd_start(cmd_start_s),
    .cmd_stop (cmd_stop_s),
    .dec_load (dec_load_s)
  );

  tx_state_e        state_r;
  tx_state_e        state_nxt_s;
  logic             load_s;
  logic             hs_s;
  logic             keep_s;
  logic [7:0]       tx_byte_s;
  logic [7:0]       dcnt_r;
  logic             hold_full_r;
  logic [ADC_W-1:0] hold_data_r;
  logic [7:0]       frame_hi_r;
  logic [7:0]       frame_lo_r;
  logic [3:0]       seq_r;
  logic             overrun_r;
  logic             tx_valid_r;
  logic [7:0]       tx_data_r;

  assign hs_s   = tx_valid_r & tx_ready;
  assign keep_s = adc_valid & streaming_s & (dcnt_r == 8'd0);

  // TX sequencer next state; a load moves the held sample into the frame.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      TX_IDLE: begin
        if (hold_full_r) begin
          state_nxt_s = TX_HDR;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = TX_IDLE;
        end
      end
      TX_HDR: begin
        if (hs_s) state_nxt_s = TX_HI;
        else      state_nxt_s = TX_HDR;
      end
      TX_HI: begin
        if (hs_s) state_nxt_s = TX_LO;
        else      state_nxt_s = TX_HI;
      end
      TX_LO: begin
        if (hs_s && hold_full_r) begin
          state_nxt_s = TX_HDR;
          load_s      = 1'b1;
        end else if (hs_s) begin
          state_nxt_s = TX_IDLE;
        end else begin
          state_nxt_s = TX_LO;
        end
      end
      default: state_nxt_s = TX_IDLE;
    endcase
  end

  // Byte presented in the next state; frame bytes are loaded before HI/LO.
  always_comb begin
    tx_byte_s = 8'h00;
    case (state_nxt_s)
      TX_HDR:  tx_byte_s = HDR_BYTE;
      TX_HI:   tx_byte_s = frame_hi_r;
      TX_LO:   tx_byte_s = frame_lo_r;
      default: tx_byte_s = 8'h00;
    endcase
  end

  // TX state, registered TX outputs, frame shift register and sequence number.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_r    <= TX_IDLE;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'h00;
      frame_hi_r <= 8'h00;
      frame_lo_r <= 8'h00;
      seq_r      <= 4'd0;
    end else begin
      state_r    <= state_nxt_s;
      tx_valid_r <= (state_nxt_s != TX_IDLE);
      tx_data_r  <= tx_byte_s;
      if (load_s) begin
        frame_hi_r <= frame_hi_byte(seq_r, hold_data_r);
        frame_lo_r <= hold_data_r[7:0];
        seq_r      <= seq_r + 4'd1;
      end
    end
  end

  // Decimation counter, holding register and sticky overrun flag.
  // A load in the same cycle as a kept sample frees the slot for it.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      dcnt_r      <= 8'd0;
      hold_full_r <= 1'b0;
      hold_data_r <= {ADC_W{1'b0}};
      overrun_r   <= 1'b0;
    end else begin
      if (dec_load_s) begin
        dcnt_r <= 8'd0;
      end else if (adc_valid) begin
        dcnt_r <= (dcnt_r == dec_s) ? 8'd0 : dcnt_r + 8'd1;
      end
      if (cmd_stop_s) begin
        hold_full_r <= 1'b0;
      end else if (keep_s && (!hold_full_r || load_s)) begin
        hold_data_r <= adc_data;
        hold_full_r <= 1'b1;
      end else if (load_s) begin
        hold_full_r <= 1'b0;
      end
      if (cmd_start_s) begin
        overrun_r <= 1'b0;
      end else if (keep_s && hold_full_r && !load_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

  assign tx_valid  = tx_valid_r;
  assign tx_data   = tx_data_r;
  assign tx_error  = 1'b0;
  assign streaming = streaming_s;
  assign overrun   = overrun_r;

endmodule
